cwc_capture_ctrl: RTL and testbench

CWC_CAPTURE_CTRL -- requirements
Module: cwc_capture_ctrl

---
 rtl/cwc_pkg.sv | 16 +
 rtl/cwc_capture_ctrl_if.sv | 14 +
 rtl/cwc_trig_match.sv | 15 +
 rtl/cwc_capture_ctrl.sv | 131 +++++++++++++
 tb/tb_cwc_capture_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/cwc_pkg.sv
// Shared types and default sizing for the capture/trigger controller.
package cwc_pkg;

  localparam int unsigned CWC_DIN_W     = 18;
  localparam int unsigned CWC_RAM_DEPTH = 1024;
  localparam int unsigned CWC_ADDR_W    = 10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRE       = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_DONE      = 3'd4
  } cwc_cap_state_e;

endpackage

// File: rtl/cwc_capture_ctrl_if.sv
// Capture-RAM write port; the controller drives it, the RAM consumes it.
interface cwc_capture_ctrl_if #(
  parameter int unsigned DIN_W  = 18,
  parameter int unsigned ADDR_W = 10
);

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DIN_W-1:0]  ram_wdata;

  modport master (output ram_we, ram_waddr, ram_wdata);
  modport slave  (input  ram_we, ram_waddr, ram_wdata);

endinterface

// File: rtl/cwc_trig_match.sv
// Masked equality compare of the probe bus against the latched trigger value.
module cwc_trig_match
  import cwc_pkg::*;
#(
  parameter int unsigned DIN_W = CWC_DIN_W
) (
  input  logic [DIN_W-1:0] din,
  input  logic [DIN_W-1:0] trig_mask,
  input  logic [DIN_W-1:0] trig_value,
  output logic             match
);

  assign match = ((din ^ trig_value) & trig_mask) == '0;

endmodule

// File: rtl/cwc_capture_ctrl.sv
// Logic-analyser capture controller: pre-trigger fill, trigger wait with
// wrap-around, post-trigger fill, and the RAM write port that records it all.
module cwc_capture_ctrl
  import cwc_pkg::*;
#(
  parameter int unsigned DIN_W     = CWC_DIN_W,
  parameter int unsigned RAM_DEPTH = CWC_RAM_DEPTH,
  parameter int unsigned ADDR_W    = CWC_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arm,
  input  logic                abort,
  input  logic [DIN_W-1:0]    din,
  input  logic [ADDR_W-1:0]   pre_len,
  input  logic [DIN_W-1:0]    trig_mask,
  input  logic [DIN_W-1:0]    trig_value,
  cwc_capture_ctrl_if.master  ram,
  output logic                busy,
  output logic                done,
  output logic                triggered,
  output logic [ADDR_W-1:0]   trig_addr,
  output logic [ADDR_W-1:0]   start_addr,
  output logic [2:0]          state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  cwc_cap_state_e    state_q, state_n;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] post_cnt;
  logic [ADDR_W-1:0] pre_len_q;
  logic [DIN_W-1:0]  trig_mask_q;
  logic [DIN_W-1:0]  trig_value_q;
  logic              match;
  logic              start_cap;
  logic              capture;
  logic              trig_hit;

  cwc_trig_match #(.DIN_W(DIN_W)) u_trig_match (
    .din        (din),
    .trig_mask  (trig_mask_q),
    .trig_value (trig_value_q),
    .match      (match)
  );

  always_comb begin
    state_n   = state_q;
    start_cap = 1'b0;
    capture   = 1'b0;
    trig_hit  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          start_cap = 1'b1;
          state_n   = (pre_len == '0) ? ST_WAIT_TRIG : ST_PRE;
        end
      end
      // The pointer starts at zero and cannot wrap within PRE, so it doubles
      // as the pre-trigger sample counter.
      ST_PRE: begin
        capture = 1'b1;
        if (wptr == pre_len_q - ONE) state_n = ST_WAIT_TRIG;
      end
      ST_WAIT_TRIG: begin
        capture = 1'b1;
        if (match) begin
          trig_hit = 1'b1;
          state_n  = (pre_len_q == LAST_ADDR) ? ST_DONE : ST_POST;
        end
      end
      ST_POST: begin
        capture = 1'b1;
        if (post_cnt == ONE) state_n = ST_DONE;
      end
      default: state_n = ST_IDLE;
    endcase
    if (abort) begin
      state_n   = ST_IDLE;
      start_cap = 1'b0;
      capture   = 1'b0;
      trig_hit  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ram.ram_we    <= 1'b0;
      ram.ram_waddr <= '0;
      ram.ram_wdata <= '0;
      triggered     <= 1'b0;
      trig_addr     <= '0;
      wptr          <= '0;
      post_cnt      <= '0;
      pre_len_q     <= '0;
      trig_mask_q   <= '0;
      trig_value_q  <= '0;
    end else begin
      state_q    <= state_n;
      ram.ram_we <= capture;
      triggered  <= trig_hit;
      if (capture) begin
        ram.ram_waddr <= wptr;
        ram.ram_wdata <= din;
        wptr          <= wptr + ONE;
      end
      if (start_cap) begin
        pre_len_q    <= pre_len;
        trig_mask_q  <= trig_mask;
        trig_value_q <= trig_value;
        wptr         <= '0;
        trig_addr    <= '0;
        post_cnt     <= '0;
      end
      if (trig_hit) begin
        trig_addr <= wptr;
        post_cnt  <= LAST_ADDR - pre_len_q;
      end else if (state_q == ST_POST && capture) begin
        post_cnt <= post_cnt - ONE;
      end
    end
  end

  assign busy       = state_q inside {ST_PRE, ST_WAIT_TRIG, ST_POST};
  assign done       = (state_q == ST_DONE);
  assign start_addr = done ? (trig_addr - pre_len_q) : '0;
  assign state      = state_q;

endmodule

// File: tb/tb_cwc_capture_ctrl.sv
// Directed bench for cwc_capture_ctrl at RAM_DEPTH=16 with a counting probe bus.
module tb_cwc_capture_ctrl;
  import cwc_pkg::*;

  localparam int unsigned DW    = 18;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          clk = 1'b0;
  logic          rst, arm, abort;
  logic [DW-1:0] din, trig_mask, trig_value;
  logic [AW-1:0] pre_len;
  logic          busy, done, triggered;
  logic [AW-1:0] trig_addr, start_addr;
  logic [2:0]    state;

  cwc_capture_ctrl_if #(.DIN_W(DW), .ADDR_W(AW)) ram_if ();

  cwc_capture_ctrl #(.DIN_W(DW), .RAM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .abort      (abort),
    .din        (din),
    .pre_len    (pre_len),
    .trig_mask  (trig_mask),
    .trig_value (trig_value),
    .ram        (ram_if),
    .busy       (busy),
    .done       (done),
    .triggered  (triggered),
    .trig_addr  (trig_addr),
    .start_addr (start_addr),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] pre;
    logic [DW-1:0] mask;
    logic [DW-1:0] value;
    int            glitch;
    logic [AW-1:0] exp_trig;
    logic [AW-1:0] exp_start;
    int            exp_post;
    int            exp_total;
    logic [AW-1:0] exp_last_addr;
    logic [DW-1:0] exp_last_data;
  } vec_t;

  vec_t vecs[7];

  int n_cmp = 0;
  int n_bad = 0;

  int            wr_cnt, post_wr, trig_cnt, bad_pair;
  logic [AW-1:0] first_addr, last_addr, seen_trig_addr;
  logic [DW-1:0] last_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    wr_cnt = 0; post_wr = 0; trig_cnt = 0; bad_pair = 0;
    first_addr = '0; last_addr = '0; seen_trig_addr = '0; last_data = '0;
  endtask

  // Sample just after the edge, log writes/trigger, then advance the probe counter.
  task automatic tick();
    @(posedge clk);
    #1;
    if (triggered) begin
      trig_cnt++;
      seen_trig_addr = trig_addr;
    end
    if (ram_if.ram_we) begin
      if (wr_cnt == 0) first_addr = ram_if.ram_waddr;
      wr_cnt++;
      last_addr = ram_if.ram_waddr;
      last_data = ram_if.ram_wdata;
      if (trig_cnt > 0 && !triggered) post_wr++;
      if (ram_if.ram_wdata[AW-1:0] != ram_if.ram_waddr) bad_pair++;
    end
    din = din + DW'(1);
  endtask

  task automatic start_capture(input logic [AW-1:0] pre, input logic [DW-1:0] mask,
                               input logic [DW-1:0] value);
    arm = 1'b1; pre_len = pre; trig_mask = mask; trig_value = value;
    tick();
    arm = 1'b0;
    clear_log();
    din = '0;
  endtask

  task automatic wait_trig();
    for (int c = 0; c < 200; c++) begin
      tick();
      if (trig_cnt > 0) break;
    end
    chk("wait_trig timeout", 64'(trig_cnt > 0), 64'(1));
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    logic fin;
    v   = vecs[i];
    fin = 1'b0;
    start_capture(v.pre, v.mask, v.value);
    for (int c = 0; c < 200 && !fin; c++) begin
      if (v.glitch >= 0 && din == DW'(v.glitch)) begin
        arm = 1'b1; pre_len = 4'd7; trig_mask = '0; trig_value = '1;
      end
      tick();
      arm = 1'b0; pre_len = v.pre; trig_mask = v.mask; trig_value = v.value;
      fin = done;
    end
    chk($sformatf("v%0d done timeout", i), 64'(fin), 64'(1));
    chk($sformatf("v%0d trig pulses", i), 64'(trig_cnt), 64'(1));
    chk($sformatf("v%0d trig_addr", i), 64'(seen_trig_addr), 64'(v.exp_trig));
    chk($sformatf("v%0d start_addr", i), 64'(start_addr), 64'(v.exp_start));
    chk($sformatf("v%0d post writes", i), 64'(post_wr), 64'(v.exp_post));
    chk($sformatf("v%0d total writes", i), 64'(wr_cnt), 64'(v.exp_total));
    chk($sformatf("v%0d first addr", i), 64'(first_addr), 64'(0));
    chk($sformatf("v%0d last addr", i), 64'(last_addr), 64'(v.exp_last_addr));
    chk($sformatf("v%0d last data", i), 64'(last_data), 64'(v.exp_last_data));
    chk($sformatf("v%0d addr/data pairing", i), 64'(bad_pair), 64'(0));
    chk($sformatf("v%0d state", i), 64'(state), 64'(ST_DONE));
    chk($sformatf("v%0d busy", i), 64'(busy), 64'(0));
    tick();
    chk($sformatf("v%0d done held", i), 64'(done), 64'(1));
    chk($sformatf("v%0d we after done", i), 64'(ram_if.ram_we), 64'(0));
    chk($sformatf("v%0d start held", i), 64'(start_addr), 64'(v.exp_start));
  endtask

  initial begin
    // pre, mask, value, glitch, trig, start, post, total, last_addr, last_data
    vecs[0] = '{4'd0,  18'h00000, 18'h00000, -1, 4'd0,  4'd0, 15, 16, 4'd15, 18'd15};
    vecs[1] = '{4'd4,  18'h3FFFF, 18'd5,     -1, 4'd5,  4'd1, 11, 17, 4'd0,  18'd16};
    vecs[2] = '{4'd2,  18'h3FFFF, 18'd40,    -1, 4'd8,  4'd6, 13, 54, 4'd5,  18'd53};
    vecs[3] = '{4'd15, 18'h00000, 18'h00000, -1, 4'd15, 4'd0, 0,  16, 4'd15, 18'd15};
    vecs[4] = '{4'd3,  18'h00003, 18'h00002, -1, 4'd6,  4'd3, 12, 19, 4'd2,  18'd18};
    vecs[5] = '{4'd0,  18'h00020, 18'h00020, -1, 4'd0,  4'd0, 15, 48, 4'd15, 18'd47};
    vecs[6] = '{4'd2,  18'h3FFFF, 18'd40,    10, 4'd8,  4'd6, 13, 54, 4'd5,  18'd53};

    rst = 1'b1; arm = 1'b0; abort = 1'b0; din = '0;
    pre_len = '0; trig_mask = '0; trig_value = '0;
    clear_log();
    tick(); tick();
    chk("rst state", 64'(state), 64'(ST_IDLE));
    chk("rst ram_we", 64'(ram_if.ram_we), 64'(0));
    chk("rst ram_waddr", 64'(ram_if.ram_waddr), 64'(0));
    chk("rst ram_wdata", 64'(ram_if.ram_wdata), 64'(0));
    chk("rst busy/done/trig", 64'({busy, done, triggered}), 64'(0));
    chk("rst trig_addr", 64'(trig_addr), 64'(0));
    chk("rst start_addr", 64'(start_addr), 64'(0));
    rst = 1'b0;
    tick();
    chk("idle holds", 64'(state), 64'(ST_IDLE));

    for (int i = 0; i < 7; i++) run_vec(i);

    // Abort in the third POST cycle, then a fresh capture restarts at address 0.
    start_capture(4'd4, 18'h3FFFF, 18'd5);
    wait_trig();
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort state", 64'(state), 64'(ST_IDLE));
    chk("abort ram_we", 64'(ram_if.ram_we), 64'(0));
    chk("abort done/busy", 64'({done, busy}), 64'(0));
    run_vec(0);

    // Abort from DONE, then simultaneous arm+abort in IDLE stays idle.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort from done", 64'({state, done}), 64'(0));
    arm = 1'b1; abort = 1'b1; pre_len = '0; trig_mask = '0;
    tick();
    arm = 1'b0; abort = 1'b0;
    chk("arm+abort state", 64'(state), 64'(ST_IDLE));
    tick();
    chk("arm+abort quiet", 64'({ram_if.ram_we, busy, triggered, state}), 64'(0));

    // Synchronous reset in mid-POST, then a normal re-arm.
    start_capture(4'd4, 18'h3FFFF, 18'd5);
    wait_trig();
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst mid-post outputs",
        64'({ram_if.ram_we, ram_if.ram_waddr, ram_if.ram_wdata, busy, done, triggered,
             trig_addr, start_addr, state}), 64'(0));
    run_vec(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
